// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, state encoding and small arithmetic helpers
// for the SG90 servo path (angle ramp stage and PWM driver users).
package servo_pkg;

  // Default timing and pulse-width limits for an SG90 on a 25 MHz clock.
  localparam int unsigned FRAME_TICKS = 32'd500000;
  localparam int unsigned MIN_US      = 32'd650;
  localparam int unsigned MAX_US      = 32'd2600;
  localparam int unsigned STEP_US     = 32'd10;
  localparam int unsigned SPAN_US     = MAX_US - MIN_US;
  localparam int unsigned DEG_MAX     = 32'd180;
  localparam int unsigned ANGLE_W     = 32'd8;

  // Dividend width of the angle conversion: DEG_MAX * SPAN_US fits in 19 bits.
  localparam int unsigned DIV_W       = 32'd19;

  // Ramp controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RAMP = 2'd2
  } servo_state_e;

  // Angles above the mechanical range are treated as full deflection.
  function automatic int unsigned clamp_deg(input int unsigned deg);
    int unsigned res;
    if (deg > DEG_MAX) begin
      res = DEG_MAX;
    end else begin
      res = deg;
    end
    return res;
  endfunction

  // One slew step from cur toward tgt, never moving past tgt.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] res;
    if (tgt > cur) begin
      if ((tgt - cur) > step) begin
        res = cur + step;
      end else begin
        res = tgt;
      end
    end else if (cur > tgt) begin
      if ((cur - tgt) > step) begin
        res = cur - step;
      end else begin
        res = tgt;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Saturate a pulse width into the legal servo window.
  function automatic logic [31:0] clamp_us(input logic [31:0] val,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    logic [31:0] res;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/angle_to_us_div.sv
// angle_to_us_div: converts a clamped angle to a pulse width
//   us = MIN_US + floor(angle * SPAN_US / DEG_MAX)
// using a restoring divider that retires one quotient bit per cycle.
// start loads the operands; done is high in the cycle of the final
// iteration, with us already carrying the complete result.
module angle_to_us_div #(
  parameter int unsigned ANGLE_W = servo_pkg::ANGLE_W,
  parameter int unsigned MIN_US  = servo_pkg::MIN_US,
  parameter int unsigned SPAN_US = servo_pkg::SPAN_US
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [ANGLE_W-1:0] angle,
  output logic               done,
  output logic [31:0]        us
);
  import servo_pkg::*;

  localparam logic [8:0] DIVISOR   = 9'(DEG_MAX);
  localparam logic [4:0] LAST_ITER = 5'(DIV_W - 32'd1);

  logic              active_r;
  logic [4:0]        cnt_r;
  logic [7:0]        rem_r;
  logic [DIV_W-1:0]  dvd_r;

  logic [DIV_W-1:0]  dividend_s;
  logic [8:0]        trial_s;
  logic [8:0]        diff_s;
  logic              qbit_s;
  logic [7:0]        rem_nxt_s;
  logic [DIV_W-1:0]  dvd_nxt_s;

  assign dividend_s = DIV_W'(clamp_deg(32'(angle)) * SPAN_US);

  // One restoring-division iteration on the current remainder/dividend.
  always_comb begin
    trial_s   = {rem_r, dvd_r[DIV_W-1]};
    diff_s    = trial_s - DIVISOR;
    qbit_s    = 1'b0;
    rem_nxt_s = trial_s[7:0];
    if (trial_s >= DIVISOR) begin
      qbit_s    = 1'b1;
      rem_nxt_s = diff_s[7:0];
    end else begin
      qbit_s    = 1'b0;
      rem_nxt_s = trial_s[7:0];
    end
    dvd_nxt_s = {dvd_r[DIV_W-2:0], qbit_s};
  end

  assign done = active_r && (cnt_r == LAST_ITER);
  assign us   = 32'(MIN_US) + 32'(dvd_nxt_s);

  // Operand load on start, then shift one quotient bit in per cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      active_r <= 1'b0;
      cnt_r    <= 5'd0;
      rem_r    <= 8'd0;
      dvd_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= 5'd0;
      rem_r    <= 8'd0;
      dvd_r    <= dividend_s;
    end else if (active_r) begin
      rem_r    <= rem_nxt_s;
      dvd_r    <= dvd_nxt_s;
      cnt_r    <= cnt_r + 5'd1;
      active_r <= !done;
    end else begin
      active_r <= 1'b0;
      cnt_r    <= cnt_r;
      rem_r    <= rem_r;
      dvd_r    <= dvd_r;
    end
  end

endmodule

// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: accepts angle commands over valid/ready, converts them
// to a target pulse width and slews pulse_us toward it by at most STEP_US
// per servo frame. pulse_us feeds the PWM stage's control input.
// Build option: define SERVO_RAMP_BYPASS_EN to jump pulse_us straight to the
// converted target (no slew limiting, RAMP never entered).
module servo_angle_ramp #(
  parameter int unsigned FRAME_TICKS = servo_pkg::FRAME_TICKS,
  parameter int unsigned MIN_US      = servo_pkg::MIN_US,
  parameter int unsigned MAX_US      = servo_pkg::MAX_US,
  parameter int unsigned STEP_US     = servo_pkg::STEP_US,
  parameter int unsigned ANGLE_W     = servo_pkg::ANGLE_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ANGLE_W-1:0] cmd_angle,
  output logic [31:0]        pulse_us,
  output logic               frame_tick,
  output logic               busy,
  output logic               at_target
);
  import servo_pkg::*;

  localparam int unsigned    SPAN_CFG = MAX_US - MIN_US;
  localparam logic [31:0]    MID_US   = 32'((MIN_US + MAX_US) / 32'd2);
  localparam logic [31:0]    LO_US    = 32'(MIN_US);
  localparam logic [31:0]    HI_US    = 32'(MAX_US);
  localparam logic [31:0]    STEP     = 32'(STEP_US);
  localparam int unsigned    CNT_W    = (FRAME_TICKS > 32'd1) ? $clog2(FRAME_TICKS) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 32'd1);

  servo_state_e      state_r;
  servo_state_e      state_nxt_s;
  logic [CNT_W-1:0]  frame_cnt_r;
  logic [31:0]       target_r;
  logic [31:0]       target_nxt_s;
  logic [31:0]       pulse_nxt_s;
  logic [31:0]       step_s;
  logic              transfer_s;
  logic              div_start_s;
  logic              div_done_s;
  logic [31:0]       div_us_s;

  assign transfer_s = cmd_valid && cmd_ready;
  assign step_s     = step_toward(pulse_us, target_r, STEP);

  angle_to_us_div #(
    .ANGLE_W (ANGLE_W),
    .MIN_US  (MIN_US),
    .SPAN_US (SPAN_CFG)
  ) u_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (div_start_s),
    .angle (cmd_angle),
    .done  (div_done_s),
    .us    (div_us_s)
  );

  // Free-running frame counter; frame_tick marks the cycle after the wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_cnt_r <= '0;
      frame_tick  <= 1'b0;
    end else if (frame_cnt_r == CNT_LAST) begin
      frame_cnt_r <= '0;
      frame_tick  <= 1'b1;
    end else begin
      frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      frame_tick  <= 1'b0;
    end
  end

  // Next-state, next-pulse and next-target selection for the ramp FSM.
  always_comb begin
    state_nxt_s  = state_r;
    pulse_nxt_s  = pulse_us;
    target_nxt_s = target_r;
    div_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          state_nxt_s = CONV;
          div_start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONV: begin
        // Frame ticks are ignored while a conversion is in flight.
        if (div_done_s) begin
          target_nxt_s = clamp_us(div_us_s, LO_US, HI_US);
`ifdef SERVO_RAMP_BYPASS_EN
          pulse_nxt_s  = clamp_us(div_us_s, LO_US, HI_US);
          state_nxt_s  = IDLE;
`else
          if (clamp_us(div_us_s, LO_US, HI_US) == pulse_us) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RAMP;
          end
`endif
        end else begin
          state_nxt_s = CONV;
        end
      end
      RAMP: begin
        // A tick coinciding with a retarget still steps toward the old target.
        if (frame_tick) begin
          pulse_nxt_s = clamp_us(step_s, LO_US, HI_US);
        end else begin
          pulse_nxt_s = pulse_us;
        end
        if (transfer_s) begin
          state_nxt_s = CONV;
          div_start_s = 1'b1;
        end else if (pulse_nxt_s == target_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RAMP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, pulse/target registers and registered status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      pulse_us  <= MID_US;
      target_r  <= MID_US;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      at_target <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      pulse_us  <= pulse_nxt_s;
      target_r  <= target_nxt_s;
      cmd_ready <= (state_nxt_s != CONV);
      busy      <= (state_nxt_s != IDLE);
      at_target <= (state_nxt_s == IDLE) && (pulse_nxt_s == target_nxt_s);
    end
  end

endmodule
